main_memory_4c: RTL and testbench
=================================

MAIN_MEMORY_4C -- requirements
Module: main_memory_4c

Interface
REQ-001 SHALL have parameter AWIDTH, default 16, meaning byte-address width.
REQ-002 SHALL have parameter DWIDTH, default 16, meaning data word width.
REQ-003 SHALL have parameter LATENCY, default 4, meaning cycles from read acceptance to data_valid; legal range 1..8.
REQ-004 SHALL have parameter DEPTH, default 2**(AWIDTH-1), meaning number of DWIDTH-bit words stored.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-007 SHALL have port enable, input, 1 bit, request strobe sampled each rising edge.
REQ-008 SHALL have port wr, input, 1 bit, 1 = write request, 0 = read request; ignored when enable=0.
REQ-009 SHALL have port addr, input, AWIDTH bits, byte address; bit 0 ignored, word index = addr[AWIDTH-1:1].
REQ-010 SHALL have port data_in, input, DWIDTH bits, write data.
REQ-011 SHALL have port data_out, output, DWIDTH bits, read data, meaningful only while data_valid=1.
REQ-012 SHALL have port data_valid, output, 1 bit, one-cycle pulse per completed read.
REQ-013 SHALL have port busy, output, 1 bit, high while one or more reads are outstanding.

Function
REQ-014 SHALL accept one request per cycle with no back-pressure; every edge with enable=1 is a new request.
REQ-015 SHALL, on write (enable=1, wr=1), update word addr[AWIDTH-1:1] with data_in at that edge; writes produce no data_valid.
REQ-016 SHALL, on read (enable=1, wr=0), capture the word at addr[AWIDTH-1:1] at the acceptance edge (read-at-issue).
REQ-017 SHALL assert data_valid with the captured word on data_out exactly LATENCY edges after acceptance, for one cycle.
REQ-018 SHALL pipeline reads: up to LATENCY outstanding, returned in issue order, back-to-back reads giving back-to-back data_valid.
REQ-019 SHALL implement latency as a LATENCY-stage shift of {valid, data}; no FSM stall or queue overflow is possible.
REQ-020 SHALL hold data_out at zero when data_valid=0.
REQ-021 SHALL drive busy = OR of all pipeline valid bits (registered view; rises the cycle after acceptance, falls with the cycle of the last data_valid).
REQ-022 SHALL, for a write to an address with a read in flight, return the pre-write value to that read.
REQ-023 SHALL, for a read issued the edge after a write to the same address, return the new value.
REQ-024 SHALL treat addresses differing only in bit 0 as the same word.
REQ-025 SHALL wrap word index modulo DEPTH when DEPTH < 2**(AWIDTH-1).

Reset
REQ-026 SHALL, on rst=1, asynchronously clear all pipeline valid bits and data stages; data_valid=0, data_out=0, busy=0.
REQ-027 SHALL discard reads in flight when rst asserts mid-operation; no data_valid for them after release.
REQ-028 SHALL leave memory contents unchanged by reset; contents at power-up are undefined unless preloaded.
REQ-029 SHALL ignore requests while rst=1; the first request is accepted on the first rising edge with rst=0.

Verification
REQ-030 Write 0x0000<-0xABCD, next edge read 0x0000 -> data_valid exactly 4 edges after read, data_out=0xABCD, busy high for 4 cycles.
REQ-031 Writes 0x0100<-0xFF00, 0x0102<-0x1234, 0x0104<-0x5678, then reads 0x0100, 0x0102, 0x0104 on consecutive edges -> 3 consecutive data_valid cycles with 0xFF00, 0x1234, 0x5678 in order.
REQ-032 Read 0x0200 (holding 0x1111), next edge write 0x0200<-0x2222, next edge read 0x0200 -> returns 0x1111 then 0x2222.
REQ-033 Write 0x0301<-0xBEEF, read 0x0300 -> returns 0xBEEF (bit 0 ignored).
REQ-034 Issue 2 reads, assert rst 2 cycles later for 1 cycle -> data_valid, busy, data_out 0 immediately and no data_valid afterwards; memory still holds prior values on a later read.
REQ-035 Idle 10 cycles with enable=0 -> data_valid=0, busy=0, data_out=0 throughout.

Source files
------------

// File: rtl/main_memory_4c.sv
// Word-addressed memory with fixed-latency pipelined reads.
// Reads capture data at issue and shift {valid, data} through LATENCY stages.
module main_memory_4c #(
    parameter int AWIDTH  = 16,
    parameter int DWIDTH  = 16,
    parameter int LATENCY = 4,
    parameter int DEPTH   = 2**(AWIDTH-1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              wr,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] data_in,
    output logic [DWIDTH-1:0] data_out,
    output logic              data_valid,
    output logic              busy
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DWIDTH-1:0]              mem [DEPTH];
    logic [AWIDTH-1:0]              word_ext;
    logic [AWIDTH-1:0]              idx_full;
    logic [IW-1:0]                  idx;
    logic                           rd_acc;
    logic                           wr_acc;
    logic [LATENCY:1]               vld_pipe;
    logic [LATENCY:1][DWIDTH-1:0]   dat_pipe;
    logic                           unused_bits;

    // Byte address bit 0 is dropped; the word index wraps when DEPTH is small.
    assign word_ext    = {1'b0, addr[AWIDTH-1:1]};
    assign idx_full    = word_ext % AWIDTH'(DEPTH);
    assign idx         = idx_full[IW-1:0];
    assign unused_bits = ^{addr[0], idx_full[AWIDTH-1:IW]};

    assign rd_acc = enable & ~wr;
    assign wr_acc = enable & wr;

    // Memory shares the reset-qualified block so requests are ignored during
    // reset, but the reset branch deliberately leaves contents untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            if (wr_acc)
                mem[idx] <= data_in;
            vld_pipe[1] <= rd_acc;
            dat_pipe[1] <= rd_acc ? mem[idx] : '0;
            for (int i = 2; i <= LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign data_valid = vld_pipe[LATENCY];
    assign data_out   = vld_pipe[LATENCY] ? dat_pipe[LATENCY] : '0;
    assign busy       = |vld_pipe;

endmodule

// File: tb/tb_main_memory_4c.sv
// Directed bench for main_memory_4c: latency, ordering, hazards, bit-0 aliasing, reset.
module tb_main_memory_4c;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;
    logic        data_valid;
    logic        busy;
    int          n_chk = 0;
    int          n_err = 0;

    main_memory_4c #(.AWIDTH(16), .DWIDTH(16), .LATENCY(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(data_out), .data_valid(data_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic outs(input string tag, input logic v, input logic b, input logic [15:0] d);
        chk({tag, ".dv"},   {31'd0, data_valid}, {31'd0, v});
        chk({tag, ".busy"}, {31'd0, busy},       {31'd0, b});
        chk({tag, ".data"}, {16'd0, data_out},   {16'd0, d});
    endtask

    task automatic cyc(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
        enable  = en;
        wr      = w;
        addr    = a;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    initial begin
        @(posedge clk); #1;
        outs("reset", 1'b0, 1'b0, 16'h0000);
        rst = 1'b0;

        // single write then read, data in 4th cycle after acceptance
        cyc(1'b1, 1'b1, 16'h0000, 16'hABCD);
        cyc(1'b1, 1'b0, 16'h0000, 16'h0000);
        outs("r030.k1", 1'b0, 1'b1, 16'h0000);
        idle(); outs("r030.k2", 1'b0, 1'b1, 16'h0000);
        idle(); outs("r030.k3", 1'b0, 1'b1, 16'h0000);
        idle(); outs("r030.k4", 1'b1, 1'b1, 16'hABCD);
        idle(); outs("r030.done", 1'b0, 1'b0, 16'h0000);

        // back-to-back reads return back-to-back in order
        cyc(1'b1, 1'b1, 16'h0100, 16'hFF00);
        cyc(1'b1, 1'b1, 16'h0102, 16'h1234);
        cyc(1'b1, 1'b1, 16'h0104, 16'h5678);
        cyc(1'b1, 1'b0, 16'h0100, 16'h0000);
        cyc(1'b1, 1'b0, 16'h0102, 16'h0000);
        cyc(1'b1, 1'b0, 16'h0104, 16'h0000);
        outs("r031.k3", 1'b0, 1'b1, 16'h0000);
        idle(); outs("r031.d0", 1'b1, 1'b1, 16'hFF00);
        idle(); outs("r031.d1", 1'b1, 1'b1, 16'h1234);
        idle(); outs("r031.d2", 1'b1, 1'b1, 16'h5678);
        idle(); outs("r031.done", 1'b0, 1'b0, 16'h0000);

        // read / write / read on the same word
        cyc(1'b1, 1'b1, 16'h0200, 16'h1111);
        cyc(1'b1, 1'b0, 16'h0200, 16'h0000);
        cyc(1'b1, 1'b1, 16'h0200, 16'h2222);
        cyc(1'b1, 1'b0, 16'h0200, 16'h0000);
        idle(); outs("r032.old", 1'b1, 1'b1, 16'h1111);
        idle(); outs("r032.gap", 1'b0, 1'b1, 16'h0000);
        idle(); outs("r032.new", 1'b1, 1'b1, 16'h2222);
        idle(); outs("r032.done", 1'b0, 1'b0, 16'h0000);

        // bit 0 of the byte address is ignored
        cyc(1'b1, 1'b1, 16'h0301, 16'hBEEF);
        cyc(1'b1, 1'b0, 16'h0300, 16'h0000);
        idle(); idle(); idle();
        outs("r033", 1'b1, 1'b1, 16'hBEEF);
        idle();

        // reset mid-flight discards reads, blocks requests, keeps memory
        cyc(1'b1, 1'b0, 16'h0100, 16'h0000);
        cyc(1'b1, 1'b0, 16'h0102, 16'h0000);
        idle(); outs("r034.pre", 1'b0, 1'b1, 16'h0000);
        #2 rst = 1'b1;
        #1 outs("r034.async", 1'b0, 1'b0, 16'h0000);
        enable  = 1'b1;
        wr      = 1'b1;
        addr    = 16'h0100;
        data_in = 16'hDEAD;
        @(posedge clk); #1;
        outs("r034.inrst", 1'b0, 1'b0, 16'h0000);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle(); outs($sformatf("r034.drop%0d", i), 1'b0, 1'b0, 16'h0000);
        end
        cyc(1'b1, 1'b0, 16'h0100, 16'h0000);
        idle(); idle(); idle();
        outs("r034.mem", 1'b1, 1'b1, 16'hFF00);
        idle(); outs("r034.done", 1'b0, 1'b0, 16'h0000);

        // quiet idle
        for (int i = 0; i < 10; i++) begin
            idle(); outs($sformatf("r035.%0d", i), 1'b0, 1'b0, 16'h0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
